// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bus for sobel_window_gen.
// The out_ready back-pressure signal exists only when SOBEL_WIN_STALL_EN is defined.
interface sobel_window_gen_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        win_valid;
  logic [71:0] win_data;
  logic [15:0] win_row;
  logic [15:0] win_col;
  logic        win_border;
  logic        frame_done;
`ifdef SOBEL_WIN_STALL_EN
  logic        out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, win_valid, win_data, win_row, win_col, win_border, frame_done
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, win_valid, win_data, win_row, win_col, win_border, frame_done
  );
`else
  modport slave (
    input  in_valid, in_data,
    output in_ready, win_valid, win_data, win_row, win_col, win_border, frame_done
  );
  modport master (
    output in_valid, in_data,
    input  in_ready, win_valid, win_data, win_row, win_col, win_border, frame_done
  );
`endif
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register, one window per pixel.
// Optional macro SOBEL_WIN_STALL_EN adds out_ready back-pressure from the window consumer.
module sobel_window_gen #(
  parameter int ROWS = 242,
  parameter int COLS = 247
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_window_gen_if.slave  bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rdy_en;
  logic [RW-1:0] r_in_row, r_out_row;
  logic [CW-1:0] r_in_col, r_out_col;

  logic [7:0]    r_lb0 [COLS];
  logic [7:0]    r_lb1 [COLS];
  logic [7:0]    r_sh [9];
  logic [7:0]    w_sh_nxt [9];
  logic [71:0]   w_win_flat;

  logic          r_win_valid;
  logic [71:0]   r_win_data;
  logic [15:0]   r_win_row, r_win_col;
  logic          r_win_border, r_frame_done;

  logic          w_adv, w_in_ready, w_accept, w_emit;
  logic          w_in_last, w_out_last, w_out_border;

  // A presented window that the consumer has not taken freezes the whole block.
`ifdef SOBEL_WIN_STALL_EN
  assign w_adv = !(r_win_valid && !bus.out_ready);
`else
  assign w_adv = 1'b1;
`endif

  assign w_in_ready   = r_rdy_en && (r_state != S_FLUSH) && w_adv;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_in_last    = (r_in_row == R_LAST) && (r_in_col == C_LAST);
  assign w_out_last   = (r_out_row == R_LAST) && (r_out_col == C_LAST);
  assign w_out_border = (r_out_row == '0) || (r_out_row == R_LAST) ||
                        (r_out_col == '0) || (r_out_col == C_LAST);

  always_comb begin
    // NOTE: every output of this process gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_FILL;
      S_FILL:  if (w_accept && (r_in_row == RW'(1)) && (r_in_col == CW'(1))) begin
                 w_emit      = 1'b1;
                 w_state_nxt = S_RUN;
               end
      S_RUN:   if (w_accept) begin
                 w_emit = 1'b1;
                 if (w_in_last) w_state_nxt = S_FLUSH;
               end
      S_FLUSH: if (w_adv) begin
                 w_emit = 1'b1;
                 if (w_out_last) w_state_nxt = S_IDLE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // New right-hand column: two rows up, one row up, and the incoming pixel.
  always_comb begin
    for (int dr = 0; dr < 3; dr++) begin
      w_sh_nxt[3*dr]   = r_sh[3*dr+1];
      w_sh_nxt[3*dr+1] = r_sh[3*dr+2];
    end
    w_sh_nxt[2] = r_lb1[r_in_col];
    w_sh_nxt[5] = r_lb0[r_in_col];
    w_sh_nxt[8] = bus.in_data;
  end

  always_comb begin
    w_win_flat = '0;
    for (int k = 0; k < 9; k++) w_win_flat[8*k +: 8] = w_sh_nxt[k];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rdy_en     <= 1'b0;
      r_in_row     <= '0;
      r_in_col     <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_win_border <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_state  <= w_state_nxt;
      if (w_accept) begin
        if (r_in_col == C_LAST) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == R_LAST) ? '0 : r_in_row + 1'b1;
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
      end
      if (w_adv) begin
        r_win_valid  <= w_emit;
        r_frame_done <= w_emit && w_out_last;
        if (w_emit) begin
          r_win_data   <= w_out_border ? '0 : w_win_flat;
          r_win_row    <= 16'(r_out_row);
          r_win_col    <= 16'(r_out_col);
          r_win_border <= w_out_border;
          if (r_out_col == C_LAST) begin
            r_out_col <= '0;
            r_out_row <= (r_out_row == R_LAST) ? '0 : r_out_row + 1'b1;
          end else begin
            r_out_col <= r_out_col + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: storage carries no reset; stale contents only ever land in border windows, which are zeroed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_in_col] <= r_lb0[r_in_col];
      r_lb0[r_in_col] <= bus.in_data;
      r_sh            <= w_sh_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_data   = r_win_data;
  assign bus.win_row    = r_win_row;
  assign bus.win_col    = r_win_col;
  assign bus.win_border = r_win_border;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x5 frame: scoreboard of modelled windows plus a
// table of hand-derived windows; adds a back-pressure scenario when SOBEL_WIN_STALL_EN is defined.
module tb_sobel_window_gen;
  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int NPIX = ROWS * COLS;
  localparam int NTBL = 10;

  typedef struct packed {
    logic [71:0] data;
    logic [15:0] r;
    logic [15:0] c;
    logic        border;
    logic        done;
  } exp_t;

  typedef struct {
    int          r;
    int          c;
    logic [71:0] data;
    logic        border;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_gen_if bus ();

  sobel_window_gen #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          n_win = 0;
  int          n_done = 0;
  int          stall_cnt = 0;
  bit          stall_test = 1'b0;
  logic [71:0] held_data;
  exp_t        q[$];
  vec_t        tbl[NTBL];
  logic [71:0] cap_data[ROWS][COLS];
  logic        cap_border[ROWS][COLS];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [71:0] pk9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic exp_t model(input int base, input int n);
    exp_t e;
    int r, c;
    r = n / COLS;
    c = n % COLS;
    e.r      = 16'(r);
    e.c      = 16'(c);
    e.border = (r == 0) || (r == ROWS - 1) || (c == 0) || (c == COLS - 1);
    e.done   = (n == NPIX - 1);
    e.data   = '0;
    if (!e.border)
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          e.data[8*(3*dr+dc) +: 8] = 8'(base + (r - 1 + dr) * COLS + (c - 1 + dc));
    return e;
  endfunction

  task automatic push_frame(input int base, input int count);
    for (int n = 0; n < count; n++) q.push_back(model(base, n));
  endtask

  task automatic clear_cap();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cap_data[r][c]   = '1;
        cap_border[r][c] = 1'b0;
      end
  endtask

  // Offer one pixel from a negedge; handshake is judged just before the next rising edge.
  task automatic send(input logic [7:0] v, output int waits);
    logic acc;
    waits = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int i = 0; i < 200 && !acc; i++) begin
      #4;
      acc = bus.in_ready;
      @(negedge clk);
      if (!acc) waits++;
    end
    check("pixel_accepted", 72'(acc), 72'(1));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", 72'(q.size()), 72'(0));
  endtask

  task automatic check_table();
    for (int i = 0; i < NTBL; i++) begin
      check($sformatf("tbl_data_%0d_%0d", tbl[i].r, tbl[i].c),
            cap_data[tbl[i].r][tbl[i].c], tbl[i].data);
      check($sformatf("tbl_border_%0d_%0d", tbl[i].r, tbl[i].c),
            72'(cap_border[tbl[i].r][tbl[i].c]), 72'(tbl[i].border));
    end
  endtask

  task automatic stream_frame(input int base);
    int w;
    for (int i = 0; i < NPIX; i++) send(8'(base + i), w);
    idle();
  endtask

  // Window monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (bus.win_valid === 1'b1) begin
      logic take;
      exp_t e;
      take = 1'b1;
`ifdef SOBEL_WIN_STALL_EN
      if (stall_test && stall_cnt <= 3 && bus.win_row == 16'd1 && bus.win_col == 16'd2) begin
        if (stall_cnt == 0) begin
          held_data     = bus.win_data;
          bus.out_ready = 1'b0;
          take          = 1'b0;
        end else begin
          check("stall_hold_data", bus.win_data, held_data);
          check("stall_in_ready", 72'(bus.in_ready), 72'(0));
          if (stall_cnt == 3) bus.out_ready = 1'b1;
          else take = 1'b0;
        end
        stall_cnt++;
      end
`endif
      if (take) begin
        n_win++;
        if (bus.frame_done) n_done++;
        if (bus.win_row < 16'(ROWS) && bus.win_col < 16'(COLS)) begin
          cap_data[bus.win_row][bus.win_col]   = bus.win_data;
          cap_border[bus.win_row][bus.win_col] = bus.win_border;
        end
        if (q.size() == 0) begin
          check("unexpected_window", 72'(bus.win_valid), 72'(0));
        end else begin
          e = q.pop_front();
          check("win_data", bus.win_data, e.data);
          check("win_row", 72'(bus.win_row), 72'(e.r));
          check("win_col", 72'(bus.win_col), 72'(e.c));
          check("win_border", 72'(bus.win_border), 72'(e.border));
          check("frame_done", 72'(bus.frame_done), 72'(e.done));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, win0, done0;
    tbl[0] = '{1, 1, pk9(0, 1, 2, 5, 6, 7, 10, 11, 12), 1'b0};
    tbl[1] = '{2, 3, pk9(7, 8, 9, 12, 13, 14, 17, 18, 19), 1'b0};
    tbl[2] = '{1, 2, pk9(1, 2, 3, 6, 7, 8, 11, 12, 13), 1'b0};
    tbl[3] = '{2, 1, pk9(5, 6, 7, 10, 11, 12, 15, 16, 17), 1'b0};
    tbl[4] = '{0, 0, 72'd0, 1'b1};
    tbl[5] = '{0, 2, 72'd0, 1'b1};
    tbl[6] = '{3, 4, 72'd0, 1'b1};
    tbl[7] = '{1, 0, 72'd0, 1'b1};
    tbl[8] = '{2, 4, 72'd0, 1'b1};
    tbl[9] = '{3, 1, 72'd0, 1'b1};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef SOBEL_WIN_STALL_EN
    bus.out_ready = 1'b1;
`endif

    // Reset state, then in_ready rises one edge after release.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 72'(bus.in_ready), 72'(0));
    check("rst_win_valid", 72'(bus.win_valid), 72'(0));
    check("rst_win_data", bus.win_data, 72'(0));
    check("rst_win_row", 72'(bus.win_row), 72'(0));
    check("rst_win_col", 72'(bus.win_col), 72'(0));
    check("rst_win_border", 72'(bus.win_border), 72'(0));
    check("rst_frame_done", 72'(bus.frame_done), 72'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 72'(bus.in_ready), 72'(1));

    // Continuous frame with pixel value = linear index.
    clear_cap();
    win0 = n_win; done0 = n_done;
    push_frame(0, NPIX);
    stream_frame(0);
    drain();
    check_table();
    check("frame_a_windows", 72'(n_win - win0), 72'(NPIX));
    check("frame_a_done_pulses", 72'(n_done - done0), 72'(1));

    // in_valid toggling; each idle cycle must show no window.
    clear_cap();
    push_frame(0, NPIX);
    for (int i = 0; i < NPIX; i++) begin
      send(8'(i), w);
      if (i < NPIX - 1) begin
        idle();
        check("toggle_win_valid_low", 72'(bus.win_valid), 72'(0));
      end
    end
    idle();
    drain();
    check_table();

    // Reset after 9 pixels: the three windows already due come out, then nothing stale.
    push_frame(0, 3);
    for (int i = 0; i < 9; i++) send(8'(i), w);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_no_pending", 72'(q.size()), 72'(0));
    check("mid_rst_win_valid", 72'(bus.win_valid), 72'(0));
    check("mid_rst_in_ready", 72'(bus.in_ready), 72'(0));
    rst_n = 1'b1;
    @(negedge clk);
    clear_cap();
    done0 = n_done;
    push_frame(0, NPIX);
    stream_frame(0);
    drain();
    check_table();
    check("after_rst_done_pulses", 72'(n_done - done0), 72'(1));

    // Back-to-back frames with in_valid held high; second frame offset by 100.
    win0 = n_win; done0 = n_done;
    push_frame(0, NPIX);
    push_frame(100, NPIX);
    for (int i = 0; i < 2 * NPIX; i++) begin
      send(8'((i < NPIX) ? i : 100 + i - NPIX), w);
      if (i == NPIX) check("flush_ready_low_cycles", 72'(w), 72'(COLS + 1));
    end
    idle();
    drain();
    check("b2b_windows", 72'(n_win - win0), 72'(2 * NPIX));
    check("b2b_done_pulses", 72'(n_done - done0), 72'(2));

`ifdef SOBEL_WIN_STALL_EN
    // Consumer refuses window (1,2) for three edges.
    clear_cap();
    stall_cnt  = 0;
    stall_test = 1'b1;
    push_frame(0, NPIX);
    stream_frame(0);
    drain();
    stall_test = 1'b0;
    check("stall_observations", 72'(stall_cnt), 72'(4));
    check_table();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
